fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end. Owns the PC and drives the address into the instruction memory.
- Instruction memory is synchronous. It raises a stall on alternate cycles and flags misaligned addresses combinationally.
- Block hands fetched words to decode through a one-entry valid/ready output register.
- Applies exception and branch redirects, and discards stale in-flight reads.

Parameters:
- RESET_PC, 32'hBFC00000, PC value loaded on reset.
- PC_STEP, 4, PC increment on each accepted fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  fetch address to instruction memory; equals current PC.
- imem_data  in  32  instruction word; valid only on a completion cycle.
- imem_stall  in  1  memory busy; no data this cycle.
- imem_exc  in  1  address misaligned; completes immediately.
- exc_redirect  in  1  exception/eret redirect request.
- exc_target  in  32  redirect target for exc_redirect.
- br_redirect  in  1  branch/jump redirect request.
- br_target  in  32  redirect target for br_redirect.
- id_valid  out  1  output register holds a fetched word.
- id_ready  in  1  decode accepts the word this cycle.
- id_pc  out  32  PC of the held word.
- id_inst  out  32  held instruction; 32'h0 when id_exc=1.
- id_exc  out  1  held entry is an AdEL fetch exception.
- perf_fetch_cnt  out  32  count of accepted fetches (optional feature).
- perf_stall_cnt  out  32  count of stall cycles (optional feature).

Behaviour:
- Reset values (async): pc=RESET_PC, state=FETCH, addr_stable=0, id_valid=0, id_pc=0, id_inst=0, id_exc=0, perf counters=0.
- imem_addr = pc, combinationally. pc changes only on accept or redirect.
- addr_stable: next-state value is 1 when pc is unchanged across the clock edge, 0 when pc changes that edge.
  - Ensures the RAM sampled the current pc on the previous edge.
- completion = !imem_stall && (imem_exc || addr_stable).
- out_free = !id_valid || id_ready.
- accept = state==FETCH && completion && out_free && no redirect this cycle.
- On accept:
  - id_valid<=1, id_pc<=pc.
  - Normal read: id_inst<=imem_data, id_exc<=0, pc<=pc+PC_STEP (mod 2^32, wraps 32'hFFFFFFFC to 0).
  - Misaligned read (imem_exc=1): id_inst<=0, id_exc<=1, pc unchanged, state<=EXC_HALT.
- Completion while out_free=0: word dropped, pc held, same address re-read on a later completion. id_* unchanged. This is the HOLD condition.
- Output handshake: id_valid && id_ready consumes the entry.
  - Consumed with no accept the same cycle: id_valid<=0.
  - Consumed with an accept the same cycle: back-to-back refill, id_valid stays 1.
- States:
  - FETCH: normal operation.
  - EXC_HALT: no accepts and pc frozen until a redirect. The output entry drains normally.
- Redirects:
  - exc_redirect has priority over br_redirect.
  - Selected target loads pc; state<=FETCH; addr_stable<=0; id_valid<=0 next cycle.
  - A handshake in the redirect cycle still counts as consumed by decode. Any completion in that cycle is discarded.
- Redirect to a misaligned target: next cycle imem_exc=1, so completion is immediate and accepted as id_exc=1.
- Redirect during reset: ignored. rst dominates all inputs.
- id_* outputs stay stable while id_valid=1 && id_ready=0.

Optional Feature:
- FETCH_PERF_EN defined:
  - perf_fetch_cnt increments on each accept.
  - perf_stall_cnt increments on each cycle with state==FETCH && !accept && no redirect.
  - Both wrap at 2^32 and reset to 0.
- FETCH_PERF_EN undefined: both ports tied to 32'h0, no counter flops.

Test Plan:
- Reset release with id_ready=1 and memory alternating stall/complete:
  - id_pc sequence is BFC00000, BFC00004, BFC00008.
  - id_valid pulses every second cycle.
  - id_inst matches RAM contents.
- id_ready=0 for 6 cycles after the first word:
  - id_pc holds BFC00000 and id_inst is stable.
  - pc stays BFC00004.
  - After ready rises, next delivered id_pc is BFC00004 with no word lost or duplicated.
- br_redirect to 00001000 while pc=BFC00008 and a read is in flight:
  - id_valid=0 next cycle.
  - First delivered id_pc is 00001000.
  - The in-flight BFC00008 word is never presented.
- exc_redirect to 80000180 and br_redirect to 00002000 in the same cycle: first delivered id_pc is 80000180.
- br_redirect to 00000102:
  - Next cycle delivers id_pc=00000102, id_exc=1, id_inst=0.
  - pc frozen for 10 cycles.
  - exc_redirect to 80000180 resumes fetch at 80000180.
- With FETCH_PERF_EN defined, 4 accepted fetches and 4 stall cycles: perf_fetch_cnt=4, perf_stall_cnt=4. Assert rst mid-run: both counters 0 asynchronously.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect requests and the decode-facing handshake.
// The master modport is the fetch stage; the slave modport is the memory/decode/redirect environment.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_stall;
  logic        imem_exc;
  logic        exc_redirect;
  logic [31:0] exc_target;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_exc;

  modport master (
    output imem_addr, id_valid, id_pc, id_inst, id_exc,
    input  imem_data, imem_stall, imem_exc,
    input  exc_redirect, exc_target, br_redirect, br_target, id_ready
  );

  modport slave (
    input  imem_addr, id_valid, id_pc, id_inst, id_exc,
    output imem_data, imem_stall, imem_exc,
    output exc_redirect, exc_target, br_redirect, br_target, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC, synchronous imem handshake, one-entry output register, redirects.
// Define FETCH_PERF_EN to build the accepted-fetch and stall-cycle performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic               clk,
  input  logic               rst,
  fetch_stage_if.master      bus,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt
);

  typedef enum logic {FETCH, EXC_HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        addr_stable;
  logic        id_valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_exc_q;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        completion;
  logic        out_free;
  logic        accept;
  logic        pc_changes;

  assign bus.imem_addr = pc;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_exc    = id_exc_q;

  // Data is only trustworthy once the RAM has sampled the current pc on a previous edge.
  always_comb begin
    redirect        = bus.exc_redirect || bus.br_redirect;
    redirect_target = bus.exc_redirect ? bus.exc_target : bus.br_target;
    completion      = !bus.imem_stall && (bus.imem_exc || addr_stable);
    out_free        = !id_valid_q || bus.id_ready;
    accept          = (state == FETCH) && completion && out_free && !redirect;
    pc_changes      = redirect || (accept && !bus.imem_exc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= FETCH;
      addr_stable <= 1'b0;
      id_valid_q  <= 1'b0;
      id_pc_q     <= 32'h0;
      id_inst_q   <= 32'h0;
      id_exc_q    <= 1'b0;
    end else begin
      addr_stable <= !pc_changes;
      if (redirect) begin
        pc         <= redirect_target;
        state      <= FETCH;
        id_valid_q <= 1'b0;
      end else if (accept) begin
        id_valid_q <= 1'b1;
        id_pc_q    <= pc;
        if (bus.imem_exc) begin
          id_inst_q <= 32'h0;
          id_exc_q  <= 1'b1;
          state     <= EXC_HALT;
        end else begin
          id_inst_q <= bus.imem_data;
          id_exc_q  <= 1'b0;
          pc        <= pc + PC_STEP;
        end
      end else if (id_valid_q && bus.id_ready) begin
        id_valid_q <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // A stall cycle is any FETCH cycle that neither accepts nor redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (accept)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if ((state == FETCH) && !accept && !redirect)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed phases push expected words, a negedge monitor pops on handshake.
// The memory model stalls on alternate cycles and flags misaligned addresses combinationally.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic        stall_q;
  logic [31:0] ram_q;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC(32'hBFC00000),
    .PC_STEP (32'd4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEADBEEF;
  endfunction

  // Synchronous RAM: samples the address every edge, busy on every other cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 1'b1;
      ram_q   <= 32'h0;
    end else begin
      stall_q <= ~stall_q;
      ram_q   <= mem_word(bus.imem_addr);
    end
  end

  assign bus.imem_stall = stall_q;
  assign bus.imem_data  = ram_q;
  assign bus.imem_exc   = |bus.imem_addr[1:0];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc), 1'b0});
  endtask

  // One-cycle redirect pulse starting just after the next rising edge.
  task automatic applyStimulus(input logic exc, input logic [31:0] exc_t,
                               input logic br, input logic [31:0] br_t);
    @(posedge clk); #1;
    bus.exc_redirect = exc;
    bus.exc_target   = exc_t;
    bus.br_redirect  = br;
    bus.br_target    = br_t;
    @(posedge clk); #1;
    bus.exc_redirect = 1'b0;
    bus.br_redirect  = 1'b0;
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.exc_redirect = 1'b0;
    bus.br_redirect  = 1'b0;
    bus.exc_target   = 32'h0;
    bus.br_target    = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset_imem_addr", bus.imem_addr, 32'hBFC00000);
    checkOutput("reset_id_valid", {31'h0, bus.id_valid}, 32'h0);
    checkOutput("reset_id_pc", bus.id_pc, 32'h0);
    checkOutput("reset_id_inst", bus.id_inst, 32'h0);
    checkOutput("reset_id_exc", {31'h0, bus.id_exc}, 32'h0);
    checkOutput("reset_perf_fetch", perf_fetch_cnt, 32'h0);
    checkOutput("reset_perf_stall", perf_stall_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) until every expected word was consumed, then stop accepting.
  task automatic drain_queue(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: %0d words outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    bus.id_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.id_valid && bus.id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got pc %h, required no delivery", bus.id_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("id_pc", bus.id_pc, e.pc);
        checkOutput("id_inst", bus.id_inst, e.inst);
        checkOutput("id_exc", {31'h0, bus.id_exc}, {31'h0, e.exc});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.id_ready = 1'b1;

    // Streaming from reset: a word every second cycle.
    push_word(32'hBFC00000);
    push_word(32'hBFC00004);
    push_word(32'hBFC00008);
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      checkOutput("stream_valid_pattern", {31'h0, bus.id_valid}, (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    drain_queue("stream");

    // Decode back-pressure: first word held, pc parked on the next address.
    bus.id_ready = 1'b0;
    push_word(32'hBFC00000);
    push_word(32'hBFC00004);
    push_word(32'hBFC00008);
    do_reset();
    @(posedge clk);
    for (int k = 2; k <= 7; k++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", {31'h0, bus.id_valid}, 32'h1);
      checkOutput("hold_id_pc", bus.id_pc, 32'hBFC00000);
      checkOutput("hold_id_inst", bus.id_inst, 32'h616DBEEF);
      checkOutput("hold_imem_addr", bus.imem_addr, 32'hBFC00004);
    end
    @(posedge clk); #1;
    bus.id_ready = 1'b1;
    drain_queue("hold");

    // Branch redirect while the BFC00008 read is in flight.
    bus.id_ready = 1'b1;
    push_word(32'hBFC00000);
    push_word(32'hBFC00004);
    push_word(32'h00001000);
    push_word(32'h00001004);
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("inflight_imem_addr", bus.imem_addr, 32'hBFC00008);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h00001000);
    checkOutput("br_flush_valid", {31'h0, bus.id_valid}, 32'h0);
    checkOutput("br_imem_addr", bus.imem_addr, 32'h00001000);
    drain_queue("branch");

    // Simultaneous redirects: the exception target wins.
    push_word(32'h80000180);
    push_word(32'h80000184);
    applyStimulus(1'b1, 32'h80000180, 1'b1, 32'h00002000);
    checkOutput("prio_imem_addr", bus.imem_addr, 32'h80000180);
    checkOutput("prio_flush_valid", {31'h0, bus.id_valid}, 32'h0);
    bus.id_ready = 1'b1;
    drain_queue("priority");

    // Misaligned branch target: AdEL entry, then pc frozen until an exception redirect.
    exp_q.push_back({32'h00000102, 32'h0, 1'b1});
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h00000102);
    bus.id_ready = 1'b1;
    drain_queue("adel");
    bus.id_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checkOutput("halt_imem_addr", bus.imem_addr, 32'h00000102);
      checkOutput("halt_valid", {31'h0, bus.id_valid}, 32'h0);
    end
    push_word(32'h80000180);
    push_word(32'h80000184);
    applyStimulus(1'b1, 32'h80000180, 1'b0, 32'h0);
    drain_queue("eret_resume");

    // pc wraps from FFFFFFFC to 0.
    push_word(32'hFFFFFFF8);
    push_word(32'hFFFFFFFC);
    push_word(32'h00000000);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hFFFFFFF8);
    bus.id_ready = 1'b1;
    drain_queue("wrap");

    // Performance counters over the first eight edges, then an asynchronous reset.
    bus.id_ready = 1'b1;
    push_word(32'hBFC00000);
    push_word(32'hBFC00004);
    push_word(32'hBFC00008);
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    bus.id_ready = 1'b0;
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetch_cnt", perf_fetch_cnt, 32'd4);
    checkOutput("perf_stall_cnt", perf_stall_cnt, 32'd4);
`else
    checkOutput("perf_fetch_tied", perf_fetch_cnt, 32'h0);
    checkOutput("perf_stall_tied", perf_stall_cnt, 32'h0);
`endif
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_perf_fetch", perf_fetch_cnt, 32'h0);
    checkOutput("async_perf_stall", perf_stall_cnt, 32'h0);
    checkOutput("async_id_valid", {31'h0, bus.id_valid}, 32'h0);
    checkOutput("async_imem_addr", bus.imem_addr, 32'hBFC00000);
    @(posedge clk); #1;
    checkOutput("leftover_expected", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
